// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the CPU-to-SRAM memory access controller.
// State and op encodings plus the request decode helpers.
package mem_access_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 26;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Both low or both high means no request this cycle.
  function automatic logic is_noop(
    input logic rd,
    input logic wr
  );
    return rd == wr;
  endfunction

  function automatic op_e decode_op(
    input logic wr
  );
    return wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Loadable 4-bit down-counter that paces the SRAM wait states.
// Saturates at zero; zero flag is decoded straight from the register.
module mem_wait_counter
  import mem_access_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns level-held CPU read/write requests into single SRAM cycles
// with configurable wait states and a one-cycle READY pulse.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_W,
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int WAIT_STATES = 2,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 26'h03FFFFF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
  input  logic                  CPU_READ,
  input  logic                  CPU_WRITE,
  inout  wire  [DATA_WIDTH-1:0] CPU_DATA,
  output logic                  CPU_READY,
  output logic                  CPU_ERR,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic                  RAM_CE,
  output logic                  RAM_WE,
  output logic [DATA_WIDTH-1:0] RAM_WDATA,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA
);

  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);

  state_e state_q;
  state_e state_d;
  op_e    op_q;
  op_e    op_d;

  logic                  served_q;
  logic                  served_d;
  logic                  err_q;
  logic                  err_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  logic noop;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  mem_wait_counter u_wait_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .load     (cnt_load),
    .load_val (WS_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign noop = is_noop(CPU_READ, CPU_WRITE);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    served_d = served_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    // Re-arm only after the CPU drops its request level.
    if (noop) begin
      served_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!served_q && !noop) begin
          served_d = 1'b1;
          op_d     = decode_op(CPU_WRITE);
          if (CPU_ADDR > ADDR_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            addr_d  = CPU_ADDR;
            wdata_d = CPU_DATA;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        cnt_load = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_zero) begin
          if (op_q == OP_READ) begin
            rdata_d = RAM_RDATA;
          end
          state_d = S_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      op_q     <= OP_READ;
      served_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      served_q <= served_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Address/data registers only load on a legal accept, so they
  // hold steady everywhere except the edge into ACCESS.
  assign RAM_CE    = (state_q == S_ACCESS);
  assign RAM_WE    = RAM_CE && (op_q == OP_WRITE);
  assign RAM_ADDR  = addr_q;
  assign RAM_WDATA = wdata_q;
  assign CPU_READY = (state_q == S_DONE);
  assign CPU_ERR   = err_q;

  assign CPU_DATA = (CPU_READ && !CPU_WRITE) ? rdata_q
                                             : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with W=2, W=0 and W=5 instances.
// Expected completions are queued at request time and popped on READY.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic [25:0] cpu_addr [3];
  logic        cpu_rd   [3];
  logic        cpu_wr   [3];
  logic [31:0] drv_val  [3];
  logic        drv_en   [3];
  logic [31:0] bus_val  [3];
  logic        ready    [3];
  logic        err      [3];
  logic        ce       [3];
  logic        we       [3];
  logic [25:0] ram_addr [3];
  logic [31:0] ram_wdata[3];

  typedef struct {
    int          inst;
    logic        err;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] sram_word(input logic [25:0] a);
    case (a)
      26'h10:  return 32'hDEADBEEF;
      26'h30:  return 32'hCAFEF00D;
      default: return {6'd0, a} ^ 32'hA5A5A5A5;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wire  [31:0] data_bus;
    logic [31:0] rdat;

    assign data_bus   = drv_en[g] ? drv_val[g] : 32'hzzzzzzzz;
    assign bus_val[g] = data_bus;

    // SRAM model: read word appears one edge after CE, then holds.
    always @(posedge clk) begin
      if (ce[g] && !we[g]) rdat <= sram_word(ram_addr[g]);
    end

    mem_access_ctrl #(
      .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 0 : 5))
    ) u_dut (
      .CLK       (clk),
      .RST       (rst_n),
      .CPU_ADDR  (cpu_addr[g]),
      .CPU_READ  (cpu_rd[g]),
      .CPU_WRITE (cpu_wr[g]),
      .CPU_DATA  (data_bus),
      .CPU_READY (ready[g]),
      .CPU_ERR   (err[g]),
      .RAM_ADDR  (ram_addr[g]),
      .RAM_CE    (ce[g]),
      .RAM_WE    (we[g]),
      .RAM_WDATA (ram_wdata[g]),
      .RAM_RDATA (rdat)
    );
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 3; g++) begin
        if (ready[g]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected inst=%0d got READY with nothing pending", g);
          end else begin
            exp_e = exp_q.pop_front();
            if (exp_e.inst != g || err[g] !== exp_e.err) begin
              errors++;
              $display("FAIL sb_done inst=%0d err=%b required inst=%0d err=%b",
                       g, err[g], exp_e.inst, exp_e.err);
            end
            if (exp_e.rd && cpu_rd[g] && !cpu_wr[g]) begin
              checks++;
              if (bus_val[g] !== exp_e.data) begin
                errors++;
                $display("FAIL sb_rdata inst=%0d got %h required %h",
                         g, bus_val[g], exp_e.data);
              end
            end
          end
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic e, input logic r, input logic [31:0] d);
    exp_t x;
    x.inst = i;
    x.err  = e;
    x.rd   = r;
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      cpu_addr[g] = '0;
      cpu_rd[g]   = 1'b0;
      cpu_wr[g]   = 1'b0;
      drv_val[g]  = '0;
      drv_en[g]   = 1'b0;
    end
    nxt();
    nxt();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({ready[g], err[g], ce[g], we[g], ram_addr[g], ram_wdata[g]} !== '0) begin
        errors++;
        $display("FAIL reset_outs inst=%0d got rdy=%b err=%b ce=%b we=%b addr=%h wd=%h required all 0",
                 g, ready[g], err[g], ce[g], we[g], ram_addr[g], ram_wdata[g]);
      end
    end
    cpu_rd[0] = 1'b1;
    #1;
    checks++;
    if (bus_val[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h required 00000000", bus_val[0]);
    end
    cpu_rd[0] = 1'b0;
    rst_n = 1'b1;
    nxt();
  endtask

  task automatic test_read();
    logic [31:0] want;
    push(0, 1'b0, 1'b1, 32'hDEADBEEF);
    cpu_addr[0] = 26'h10;
    cpu_rd[0]   = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      nxt();
      checks++;
      if (ce[0] !== (k == 1) || we[0] !== 1'b0) begin
        errors++;
        $display("FAIL read_ce k=%0d got ce=%b we=%b required ce=%b we=0",
                 k, ce[0], we[0], (k == 1));
      end
      if (k == 1) begin
        checks++;
        if (ram_addr[0] !== 26'h10) begin
          errors++;
          $display("FAIL read_addr got %h required 0000010", ram_addr[0]);
        end
      end
      checks++;
      if (ready[0] !== (k == 5)) begin
        errors++;
        $display("FAIL read_ready k=%0d got %b required %b", k, ready[0], (k == 5));
      end
      want = (k >= 5) ? 32'hDEADBEEF : 32'h0;
      checks++;
      if (bus_val[0] !== want) begin
        errors++;
        $display("FAIL read_bus k=%0d got %h required %h", k, bus_val[0], want);
      end
    end
    cpu_rd[0] = 1'b0;
    nxt();
  endtask

  task automatic test_write();
    logic [31:0] want;
    push(1, 1'b0, 1'b0, 32'h0);
    cpu_addr[1] = 26'h20;
    drv_val[1]  = 32'h12345678;
    drv_en[1]   = 1'b1;
    cpu_wr[1]   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      nxt();
      checks++;
      if (ce[1] !== (k == 1) || we[1] !== (k == 1)) begin
        errors++;
        $display("FAIL write_ce k=%0d got ce=%b we=%b required %b", k, ce[1], we[1], (k == 1));
      end
      checks++;
      if (ram_wdata[1] !== 32'h12345678 || ram_addr[1] !== 26'h20) begin
        errors++;
        $display("FAIL write_wdata k=%0d got %h@%h required 12345678@0000020",
                 k, ram_wdata[1], ram_addr[1]);
      end
      checks++;
      if (ready[1] !== (k == 3)) begin
        errors++;
        $display("FAIL write_ready k=%0d got %b required %b", k, ready[1], (k == 3));
      end
      want = (k == 1) ? 32'h12345678 : 32'h55AA55AA;
      checks++;
      if (bus_val[1] !== want) begin
        errors++;
        $display("FAIL write_bus k=%0d got %h required %h", k, bus_val[1], want);
      end
      drv_val[1] = 32'h55AA55AA;
    end
    cpu_wr[1] = 1'b0;
    drv_en[1] = 1'b0;
    nxt();
  endtask

  task automatic test_back_to_back();
    int n_ce  = 0;
    int n_rdy = 0;
    push(1, 1'b0, 1'b0, 32'h0);
    push(1, 1'b0, 1'b0, 32'h0);
    cpu_addr[1] = 26'h24;
    drv_val[1]  = 32'h000000A1;
    drv_en[1]   = 1'b1;
    cpu_wr[1]   = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      nxt();
      n_ce  += int'(ce[1]);
      n_rdy += int'(ready[1]);
    end
    checks++;
    if (n_ce != 1 || n_rdy != 1) begin
      errors++;
      $display("FAIL held_once got ce=%0d rdy=%0d required 1 1", n_ce, n_rdy);
    end
    cpu_wr[1] = 1'b0;
    nxt();
    cpu_wr[1] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      nxt();
      n_ce  += int'(ce[1]);
      n_rdy += int'(ready[1]);
    end
    checks++;
    if (n_ce != 2 || n_rdy != 2) begin
      errors++;
      $display("FAIL rearm got ce=%0d rdy=%0d required 2 2", n_ce, n_rdy);
    end
    cpu_wr[1] = 1'b0;
    drv_en[1] = 1'b0;
    nxt();
  endtask

  task automatic test_err();
    push(0, 1'b1, 1'b1, 32'hDEADBEEF);
    cpu_addr[0] = 26'h0400000;
    cpu_rd[0]   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      nxt();
      checks++;
      if (ce[0] !== 1'b0 || ready[0] !== (k == 1) || err[0] !== 1'b1) begin
        errors++;
        $display("FAIL err_path k=%0d got ce=%b rdy=%b err=%b required 0 %b 1",
                 k, ce[0], ready[0], err[0], (k == 1));
      end
      checks++;
      if (bus_val[0] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL err_rdata k=%0d got %h required deadbeef", k, bus_val[0]);
      end
    end
    cpu_rd[0] = 1'b0;
    nxt();
    checks++;
    if (err[0] !== 1'b1) begin
      errors++;
      $display("FAIL err_hold got %b required 1", err[0]);
    end
    push(0, 1'b0, 1'b1, 32'hDEADBEEF);
    cpu_addr[0] = 26'h10;
    cpu_rd[0]   = 1'b1;
    nxt();
    checks++;
    if (err[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b required 0", err[0]);
    end
    for (int k = 2; k <= 6; k++) nxt();
    cpu_rd[0] = 1'b0;
    nxt();
  endtask

  task automatic test_both_high();
    int n_act = 0;
    int n_bad = 0;
    cpu_addr[0] = 26'h10;
    drv_val[0]  = 32'h0F0F0F0F;
    drv_en[0]   = 1'b1;
    cpu_rd[0]   = 1'b1;
    cpu_wr[0]   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      nxt();
      n_act += int'(ce[0]) + int'(ready[0]);
      if (bus_val[0] !== 32'h0F0F0F0F) n_bad++;
    end
    checks++;
    if (n_act != 0 || n_bad != 0) begin
      errors++;
      $display("FAIL both_noop got activity=%0d bus_contention=%0d required 0 0", n_act, n_bad);
    end
    cpu_rd[0] = 1'b0;
    cpu_wr[0] = 1'b0;
    drv_en[0] = 1'b0;
    nxt();
  endtask

  task automatic test_reset_abort();
    int n_rdy = 0;
    cpu_addr[2] = 26'h30;
    cpu_rd[2]   = 1'b1;
    for (int k = 1; k <= 3; k++) nxt();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready[2], err[2], ce[2], we[2], ram_addr[2], ram_wdata[2]} !== '0
        || bus_val[2] !== 32'h0) begin
      errors++;
      $display("FAIL abort_outs got rdy=%b ce=%b addr=%h bus=%h required all 0",
               ready[2], ce[2], ram_addr[2], bus_val[2]);
    end
    cpu_rd[2] = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      nxt();
      n_rdy += int'(ready[2]);
    end
    checks++;
    if (n_rdy != 0) begin
      errors++;
      $display("FAIL abort_ready got %0d pulses required 0", n_rdy);
    end
    push(2, 1'b0, 1'b1, 32'hCAFEF00D);
    cpu_rd[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      nxt();
      checks++;
      if (ready[2] !== (k == 8) || ce[2] !== (k == 1)) begin
        errors++;
        $display("FAIL w5_timing k=%0d got rdy=%b ce=%b required %b %b",
                 k, ready[2], ce[2], (k == 8), (k == 1));
      end
    end
    checks++;
    if (bus_val[2] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL w5_rdata got %h required cafef00d", bus_val[2]);
    end
    cpu_rd[2] = 1'b0;
    nxt();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_err();
    test_both_high();
    test_reset_abort();
    nxt();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
